// File: rtl/regbank_arbiter_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the I2C / core register-bank arbiter.
// Holds the arbiter state encoding and the default bus widths.
// No logic; imported by regbank_arbiter.
package regbank_arbiter_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    // IDLE is the only state that can issue a RAM access; the two wait
    // states are the single cycle in which the RAM read data is valid.
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_I2C_RD_WAIT  = 2'd1,
        ST_CORE_RD_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/regbank_arbiter.sv
`timescale 1ns/1ps
// Purpose: shares one single-port sync RAM between an I2C slave (posted writes,
//          read prefetch) and a local core (req/gnt, rvalid one cycle after gnt).
// Latency/backpressure: one access per IDLE slot; reads hold the port 2 cycles;
//          core waits on core_gnt, I2C writes are posted (overrun flagged).
// Ports:
//   clk, rst                  - clock, async active-high reset
//   i2c_rw/addr/wen/wdata     - I2C application bus; i2c_rdata_used pops prefetch
//   i2c_rdata                 - prefetched read data (stale after pop until refill)
//   core_req/we/addr/wdata    - core request, held until core_gnt
//   core_gnt/rvalid/rdata     - grant pulse, read return one cycle after grant
//   mem_en/we/addr/wdata      - RAM command; mem_rdata valid 1 cycle after a read
//   err_overrun/err_underrun  - sticky error flags, cleared only by reset
module regbank_arbiter
    import regbank_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    // I2C slave application bus
    input  logic              i2c_rw,
    input  logic [ADDR_W-1:0] i2c_addr,
    input  logic              i2c_wen,
    input  logic [DATA_W-1:0] i2c_wdata,
    input  logic              i2c_rdata_used,
    output logic [DATA_W-1:0] i2c_rdata,
    // local core request
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    // single-port synchronous RAM
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    // sticky errors
    output logic              err_overrun,
    output logic              err_underrun
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            r_state;
    state_e            w_state_nxt;

    // posted I2C write
    logic              r_wp_vld;
    logic [ADDR_W-1:0] r_wp_addr;
    logic [DATA_W-1:0] r_wp_data;

    // prefetch buffer
    logic              r_pf_vld;
    logic [ADDR_W-1:0] r_pf_addr;
    logic [DATA_W-1:0] r_pf_data;

    // address of the prefetch read currently in flight
    logic [ADDR_W-1:0] r_rd_addr;

    // set when the core was made to wait behind a prefetch
    logic              r_fair;

    logic [DATA_W-1:0] r_core_rdata;
    logic              r_err_ovr;
    logic              r_err_udr;

    // issue decisions for the current IDLE slot (one-hot or all zero)
    logic              w_iss_wp;
    logic              w_iss_pf;
    logic              w_iss_core;

    logic              w_pf_need;
    logic              w_core_wr;
    logic              w_pf_hit;
    logic              w_cap_hit;
    logic              w_inval_pf;
    logic              w_inval_cap;

    assign w_pf_need = i2c_rw & ~r_pf_vld;
    assign w_core_wr = w_iss_core & core_we;

    // A write "to" an address covers a new I2C write this cycle, one still
    // posted, and a core write being issued now. Counting the posted write
    // keeps a prefetch from ever capturing data older than that write.
    assign w_pf_hit  = (i2c_wen  && (i2c_addr  == r_pf_addr)) ||
                       (r_wp_vld && (r_wp_addr == r_pf_addr)) ||
                       (w_core_wr && (core_addr == r_pf_addr));

    // No core write can issue in I2C_RD_WAIT, so only I2C sources matter.
    assign w_cap_hit = (i2c_wen  && (i2c_addr  == r_rd_addr)) ||
                       (r_wp_vld && (r_wp_addr == r_rd_addr));

    assign w_inval_pf  = i2c_rdata_used | (i2c_addr != r_pf_addr) | w_pf_hit;
    assign w_inval_cap = i2c_rdata_used | (i2c_addr != r_rd_addr) | w_cap_hit;

    // ------------------------------------------------------------------
    // FSM: next state and slot arbitration
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_iss_wp    = 1'b0;
        w_iss_pf    = 1'b0;
        w_iss_core  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (r_wp_vld) begin
                    // posted write first, so a prefetch of the same
                    // address afterwards sees the new data
                    w_iss_wp = 1'b1;
                end else if (r_fair && core_req) begin
                    w_iss_core = 1'b1;
                    if (!core_we) begin
                        w_state_nxt = ST_CORE_RD_WAIT;
                    end
                end else if (w_pf_need) begin
                    w_iss_pf    = 1'b1;
                    w_state_nxt = ST_I2C_RD_WAIT;
                end else if (core_req) begin
                    w_iss_core = 1'b1;
                    if (!core_we) begin
                        w_state_nxt = ST_CORE_RD_WAIT;
                    end
                end
            end
            ST_I2C_RD_WAIT:  w_state_nxt = ST_IDLE;
            ST_CORE_RD_WAIT: w_state_nxt = ST_IDLE;
            default:         w_state_nxt = ST_IDLE;
        endcase

        // Inputs may still toggle while reset is held; never issue then.
        if (rst) begin
            w_state_nxt = ST_IDLE;
            w_iss_wp    = 1'b0;
            w_iss_pf    = 1'b0;
            w_iss_core  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // RAM command mux; fields are zero outside issue cycles
    // ------------------------------------------------------------------
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_iss_wp) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = r_wp_addr;
            mem_wdata = r_wp_data;
        end else if (w_iss_pf) begin
            mem_en    = 1'b1;
            mem_addr  = i2c_addr;
        end else if (w_iss_core) begin
            mem_en    = 1'b1;
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_we ? core_wdata : '0;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_wp_vld     <= 1'b0;
            r_wp_addr    <= '0;
            r_wp_data    <= '0;
            r_pf_vld     <= 1'b0;
            r_pf_addr    <= '0;
            r_pf_data    <= '0;
            r_rd_addr    <= '0;
            r_fair       <= 1'b0;
            r_core_rdata <= '0;
            r_err_ovr    <= 1'b0;
            r_err_udr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            // Posted write: a new pulse always wins (overwrites the entry).
            // A pulse in the cycle the old entry issues is not an overrun.
            if (i2c_wen) begin
                r_wp_vld  <= 1'b1;
                r_wp_addr <= i2c_addr;
                r_wp_data <= i2c_wdata;
            end else if (w_iss_wp) begin
                r_wp_vld  <= 1'b0;
            end
            if (i2c_wen && r_wp_vld && !w_iss_wp) begin
                r_err_ovr <= 1'b1;
            end

            if (i2c_rdata_used && !r_pf_vld) begin
                r_err_udr <= 1'b1;
            end

            if (w_iss_pf) begin
                r_rd_addr <= i2c_addr;
            end

            // Prefetch buffer: capture unless something invalidated the
            // read in flight; a dropped capture simply reissues from IDLE.
            if (r_state == ST_I2C_RD_WAIT) begin
                if (!w_inval_cap) begin
                    r_pf_vld  <= 1'b1;
                    r_pf_addr <= r_rd_addr;
                    r_pf_data <= mem_rdata;
                end
            end else if (w_inval_pf) begin
                r_pf_vld <= 1'b0;
            end

            if (w_iss_pf && core_req) begin
                r_fair <= 1'b1;
            end else if (w_iss_core) begin
                r_fair <= 1'b0;
            end

            if (r_state == ST_CORE_RD_WAIT) begin
                r_core_rdata <= mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign i2c_rdata    = r_pf_data;
    assign core_gnt     = w_iss_core;
    assign core_rvalid  = (r_state == ST_CORE_RD_WAIT);
    // Live RAM data in the return cycle, then held until the next core read.
    assign core_rdata   = (r_state == ST_CORE_RD_WAIT) ? mem_rdata : r_core_rdata;
    assign err_overrun  = r_err_ovr;
    assign err_underrun = r_err_udr;

endmodule

// File: tb/tb_regbank_arbiter.sv
`timescale 1ns/1ps
// Bench for regbank_arbiter: directed I2C/core scenarios with literal
// expectations, plus a per-cycle monitor checking handshake timing and
// read data against the bench-owned RAM contents.
module tb_regbank_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       i2c_rw, i2c_wen, i2c_rdata_used;
    logic [7:0] i2c_addr, i2c_wdata, i2c_rdata;
    logic       core_req, core_we, core_gnt, core_rvalid;
    logic [7:0] core_addr, core_wdata, core_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       err_overrun, err_underrun;

    int checks = 0;
    int errors = 0;
    int n_wr61 = 0;

    logic [37:0] outs;
    assign outs = {i2c_rdata, core_gnt, core_rvalid, core_rdata, mem_en, mem_we,
                   mem_addr, mem_wdata, err_overrun, err_underrun};

    always #5 clk = ~clk;

    regbank_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .i2c_rw(i2c_rw), .i2c_addr(i2c_addr), .i2c_wen(i2c_wen),
        .i2c_wdata(i2c_wdata), .i2c_rdata_used(i2c_rdata_used), .i2c_rdata(i2c_rdata),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .core_rdata(core_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .err_overrun(err_overrun), .err_underrun(err_underrun)
    );

    // Single-port synchronous RAM model.
    logic [7:0] ram [0:255];
    logic       ram_init;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'hC3;
            ram[8'h20] <= 8'h11;
            ram[8'h21] <= 8'h22;
            ram[8'h22] <= 8'h33;
            ram[8'h05] <= 8'h5C;
            ram[8'h30] <= 8'h00;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Per-cycle rules: rvalid exactly one cycle after a read grant carrying
    // the RAM word at the granted address; a grant is the cycle the core's
    // access is on the RAM port; a new prefetch value equals the RAM word at
    // the address the I2C side is reading.
    task automatic monitor();
        logic       prev_rd = 1'b0;
        logic [7:0] exp_rd  = 8'h00;
        logic [7:0] last_pf = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_rd = 1'b0;
            end else begin
                chk("m_rvalid_timing", core_rvalid, prev_rd);
                if (core_rvalid) chk("m_core_rdata", core_rdata, exp_rd);
                if (core_gnt) begin
                    chk("m_gnt_mem_en", mem_en, 1);
                    chk("m_gnt_mem_addr", mem_addr, core_addr);
                    chk("m_gnt_mem_we", mem_we, core_we);
                    if (core_we) chk("m_gnt_mem_wdata", mem_wdata, core_wdata);
                end
                if (mem_we) begin
                    chk("m_we_without_en", mem_en, 1);
                    if (mem_addr == 8'h61) n_wr61++;
                end
                if (i2c_rdata != last_pf) chk("m_prefetch_data", i2c_rdata, ram[i2c_addr]);
                prev_rd = core_gnt & ~core_we;
                if (core_gnt) exp_rd = ram[core_addr];
            end
            last_pf = i2c_rdata;
        end
    endtask

    initial begin
        int n;
        int n_rv;
        rst = 1'b1; ram_init = 1'b1;
        i2c_rw = 1'b1; i2c_addr = 8'h20; i2c_wen = 1'b0; i2c_wdata = 8'h00;
        i2c_rdata_used = 1'b0;
        core_req = 1'b0; core_we = 1'b0; core_addr = 8'h00; core_wdata = 8'h00;
        fork
            monitor();
            begin
                // reset: all outputs zero even with a read request pending
                mid();
                chk("reset_outputs", outs, 0);
                repeat (2) @(posedge clk);
                #1; rst = 1'b0; ram_init = 1'b0; i2c_rw = 1'b0;

                // posted I2C write, core read held off by it
                nxt(); i2c_wen = 1'b1; i2c_addr = 8'h10; i2c_wdata = 8'hA5;
                mid(); chk("a_no_mem_same_cycle", mem_en, 0);
                nxt(); i2c_wen = 1'b0; core_req = 1'b1; core_we = 1'b0; core_addr = 8'h40;
                mid();
                chk("a_wr_en", {mem_en, mem_we}, 2'b11);
                chk("a_wr_addr", mem_addr, 8'h10);
                chk("a_wr_data", mem_wdata, 8'hA5);
                chk("a_gnt_low", core_gnt, 0);
                nxt(); mid();
                chk("a_core_gnt", core_gnt, 1);
                chk("a_core_addr", mem_addr, 8'h40);
                nxt(); core_req = 1'b0;
                mid();
                chk("a_rvalid", core_rvalid, 1);
                chk("a_rdata", core_rdata, 8'h83);
                nxt(); mid();
                chk("a_rdata_hold", {core_rvalid, core_rdata}, {1'b0, 8'h83});

                // I2C read stream 0x20..0x22
                nxt(); i2c_rw = 1'b1; i2c_addr = 8'h20;
                for (int k = 0; k < 3; k++) begin
                    nxt(); nxt(); mid();
                    chk("b_stream_data", i2c_rdata, (k == 0) ? 8'h11 : (k == 1) ? 8'h22 : 8'h33);
                    nxt(); i2c_rdata_used = 1'b1; i2c_addr = i2c_addr + 8'd1;
                    nxt(); i2c_rdata_used = 1'b0;
                end
                nxt(); i2c_rw = 1'b0;
                repeat (3) nxt();
                mid(); chk("b_no_underrun", err_underrun, 0);

                // contention: prefetch and core read in the same slot
                nxt(); i2c_addr = 8'h50;
                nxt(); i2c_rw = 1'b1; core_req = 1'b1; core_we = 1'b0; core_addr = 8'h05;
                mid();
                chk("c_prefetch_first", {mem_en, mem_we, mem_addr, core_gnt}, {2'b10, 8'h50, 1'b0});
                n = 0;
                do begin
                    nxt(); mid(); n++;
                end while (!core_gnt && n < 4);
                chk("c_gnt_within_2", (core_gnt && n <= 2), 1);
                nxt(); core_req = 1'b0;
                mid();
                chk("c_rvalid_data", {core_rvalid, core_rdata}, {1'b1, 8'h5C});
                chk("c_prefetch_data", i2c_rdata, 8'h93);

                // hazard: core write to the prefetched address
                nxt(); i2c_addr = 8'h30;
                repeat (3) nxt();
                mid(); chk("d_pf_0x30", i2c_rdata, 8'h00);
                nxt(); core_req = 1'b1; core_we = 1'b1; core_addr = 8'h30; core_wdata = 8'h7E;
                mid(); chk("d_core_wr", {core_gnt, mem_we, mem_addr, mem_wdata}, {2'b11, 8'h30, 8'h7E});
                nxt(); core_req = 1'b0; core_we = 1'b0;
                mid(); chk("d_reissue", {mem_en, mem_we, mem_addr, i2c_rdata}, {2'b10, 8'h30, 8'h00});
                nxt(); nxt(); mid(); chk("d_pf_new", i2c_rdata, 8'h7E);

                // overrun: two I2C writes while the port is busy with a core read
                nxt(); i2c_rw = 1'b0;
                nxt(); core_req = 1'b1; core_addr = 8'h06;
                i2c_wen = 1'b1; i2c_addr = 8'h61; i2c_wdata = 8'hAA;
                mid(); chk("e_core_gnt", core_gnt, 1);
                nxt(); core_req = 1'b0; i2c_addr = 8'h62; i2c_wdata = 8'hBB;
                mid();
                chk("e_rvalid_data", {core_rvalid, core_rdata}, {1'b1, 8'hC5});
                chk("e_ovr_not_yet", err_overrun, 0);
                nxt(); i2c_wen = 1'b0;
                mid();
                chk("e_second_write", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 8'h62, 8'hBB});
                chk("e_overrun", err_overrun, 1);
                // underrun: pop with no valid prefetch
                nxt(); i2c_rdata_used = 1'b1;
                mid(); chk("e_udr_not_yet", err_underrun, 0);
                nxt(); i2c_rdata_used = 1'b0;
                mid();
                chk("e_underrun", err_underrun, 1);
                chk("e_stale_rdata", i2c_rdata, 8'h7E);
                chk("e_overrun_sticky", err_overrun, 1);
                chk("e_first_write_dropped", n_wr61, 0);

                // reset in the middle of a core read
                nxt(); core_req = 1'b1; core_we = 1'b0; core_addr = 8'h07;
                mid(); chk("f_gnt", core_gnt, 1);
                nxt(); core_req = 1'b0;
                #1; chk("f_in_rd_wait", core_rvalid, 1);
                rst = 1'b1;
                #1; chk("f_async_outputs_zero", outs, 0);
                nxt(); rst = 1'b0;
                n_rv = 0;
                repeat (4) begin
                    mid();
                    if (core_rvalid) n_rv++;
                    nxt();
                end
                chk("f_no_rvalid_after_rst", n_rv, 0);
                chk("f_errors_cleared", {err_overrun, err_underrun}, 2'b00);
            end
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regbank_arbiter.md
REGBANK_ARBITER -- requirements
Module: regbank_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning register address width.
REQ-002 SHALL have parameter DATA_W, default 8, meaning register data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports i2c_rw, i2c_addr[ADDR_W], i2c_wen, i2c_wdata[DATA_W] and i2c_rdata_used, all inputs, forming the I2C slave application bus.
REQ-006 SHALL have port i2c_rdata, output, DATA_W, the prefetched read data for the I2C slave.
REQ-007 SHALL have ports core_req, core_we, core_addr[ADDR_W] and core_wdata[DATA_W], all inputs, forming the local core request.
REQ-008 SHALL have ports core_gnt (output, 1), core_rvalid (output, 1) and core_rdata (output, DATA_W).
REQ-009 SHALL have ports mem_en, mem_we, mem_addr[ADDR_W] and mem_wdata[DATA_W], all outputs, driving a single-port synchronous RAM; mem_rdata (input, DATA_W) is valid 1 cycle after mem_en with mem_we=0.
REQ-010 SHALL have ports err_overrun and err_underrun, outputs, 1, sticky error flags.

Function
REQ-011 SHALL latch an i2c_wen pulse into a write-pending register (addr, data) in the same cycle; the pending write issues on mem at the next IDLE slot.
REQ-012 SHALL keep a prefetch buffer (pf_valid, pf_addr, pf_data) and drive i2c_rdata = pf_data at all times.
REQ-013 SHALL clear pf_valid on any of: i2c_rdata_used, i2c_addr != pf_addr, an I2C or core write to pf_addr.
REQ-014 SHALL, when i2c_rw=1 and pf_valid=0, issue a read of the current i2c_addr.
REQ-015 SHALL use states IDLE, I2C_RD_WAIT and CORE_RD_WAIT.
REQ-016 In IDLE the priority SHALL be: pending I2C write, then I2C prefetch, then core_req.
REQ-017 An I2C or core write SHALL occupy one cycle (IDLE->IDLE); a read SHALL go IDLE->*_RD_WAIT, capture mem_rdata, then return to IDLE.
REQ-018 In I2C_RD_WAIT, capture SHALL set pf_valid=1 and pf_addr to the issued address, unless an invalidation (REQ-013) occurs in that cycle; then pf_valid stays 0 and the read reissues.
REQ-019 Core handshake: the requester SHALL hold core_req and its fields stable until core_gnt; core_gnt SHALL be a 1-cycle pulse in the cycle mem is issued.
REQ-020 Core reads SHALL pulse core_rvalid with core_rdata exactly 1 cycle after core_gnt; core_rdata SHALL hold its value until the next core read.
REQ-021 Fairness: if core_req was pending while an I2C prefetch was served, the next IDLE slot SHALL go to the core, unless an I2C write is pending.
REQ-022 A pending I2C write SHALL order before a prefetch to the same address, so the prefetch returns the new data.
REQ-023 i2c_wen while a write is already pending SHALL overwrite the pending entry and set err_overrun.
REQ-024 i2c_rdata_used while pf_valid=0 SHALL set err_underrun; i2c_rdata keeps its stale value.
REQ-025 mem_en SHALL be high only in issue cycles; mem_we=1 only for writes; at most one mem access per cycle.

Reset
REQ-026 rst SHALL force, asynchronously: state=IDLE, pf_valid=0, pf_addr=0, pf_data=0, write-pending=0, fairness flag=0.
REQ-027 rst SHALL force all outputs to 0: i2c_rdata, core_gnt, core_rvalid, core_rdata, all mem_* outputs, err_overrun, err_underrun.
REQ-028 Reset mid-read SHALL discard the outstanding read; no core_rvalid SHALL follow.
REQ-029 The error flags SHALL clear only on rst.

Structure
REQ-030 A shared package SHALL hold the state enum and the ADDR_W/DATA_W default constants.
REQ-031 No sub-module is required; the block SHALL be a single module.

Verification
REQ-032 I2C write: i2c_wen with addr 0x10, data 0xA5 while idle -> mem write to 0x10 with data 0xA5 on the next cycle; core_gnt stays low that cycle.
REQ-033 I2C read stream: rw=1, addr=0x20 with RAM[0x20..0x22]=11,22,33, pulse rdata_used and increment addr three times -> i2c_rdata shows 0x11, 0x22, 0x33 in turn; err_underrun stays 0.
REQ-034 Contention: core_req read of 0x05 in the same cycle as an I2C prefetch -> prefetch is served first and core_gnt follows within 2 cycles; core_rvalid carries RAM[0x05].
REQ-035 Hazard: prefetch valid for 0x30 (0x00), then a core write of 0x30=0x7E -> pf_valid clears and the reissued prefetch gives i2c_rdata=0x7E.
REQ-036 Errors: two i2c_wen pulses before one is serviced -> err_overrun=1 and only the second write reaches mem; rdata_used with pf_valid=0 -> err_underrun=1.
REQ-037 Reset mid-read: assert rst during CORE_RD_WAIT -> all outputs 0 at once and no core_rvalid after rst is released.
